aha_tlx_multi_lane_trainer: RTL and testbench
=============================================

// Module: aha_tlx_multi_lane_trainer
// PURPOSE
//  Parametrised multi-lane receiver for TLX link training. It is the next generation
//  of the single-lane input checker. Each lane deserialises D_IN, searches every bit
//  phase for SEQUENCE, then locks word alignment, and counts word matches and errors.
//  It sits between the TLX pad inputs and the training-control register block.
// PARAMETERS
//  NUM_LANES  4   number of independent serial lanes
//  SEQ_W      32  training word width, in bits (>=2)
//  CNT_W      32  width of LENGTH, the word counter and the per-lane counters
// PORTS
//  CLK          in   1              clock
//  RESETn       in   1              asynchronous active-low reset
//  D_IN         in   NUM_LANES      serial data, one bit per lane per cycle
//  LANE_EN      in   NUM_LANES      lane enable; sampled on the start pulse, held in lane_en_r
//  START        in   1              level; a rising edge starts training
//  CLEAR        in   1              level; a rising edge aborts training and clears status
//  SEQUENCE     in   SEQ_W          expected word; bit 0 is the first bit received
//  LENGTH       in   CNT_W          training length, in words
//  AUTO_STOP    in   1              1: stop after LENGTH words; 0: run until CLEAR
//  DONE         out  1              sticky completion flag
//  ACTIVE       out  1              state==TRAIN
//  LOCKED       out  NUM_LANES      per-lane word-alignment lock
//  MATCH_COUNT  out  NUM_LANES*CNT_W per-lane aligned matches; lane n at [n*CNT_W +: CNT_W]
//  ERR_COUNT    out  NUM_LANES*CNT_W per-lane aligned mismatches, same packing
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0. Windows, lane_en_r, phase and word counters 0.
//  Edge detection: start_q<=START, start_p=START&~start_q. clear_p is the same on CLEAR.
//    No synchroniser inside this block.
//  FSM (IDLE/TRAIN/FINISH):
//   - IDLE->TRAIN on start_p&~clear_p. clear_p wins when both fire.
//   - TRAIN->IDLE on clear_p.
//   - TRAIN->FINISH when AUTO_STOP and shift_cnt==LENGTH*SEQ_W
//     (cnt_done: bit_idx==SEQ_W-1 and word_cnt==LENGTH-1).
//   - FINISH->IDLE after 1 cycle.
//   - LENGTH==0 with AUTO_STOP: TRAIN lasts exactly 1 cycle.
//   - start_p in TRAIN or FINISH is ignored.
//  start_p accepted in IDLE:
//   - clears LOCKED, MATCH_COUNT, ERR_COUNT, DONE, windows, bit_idx and word_cnt;
//   - latches LANE_EN into lane_en_r.
//  TRAIN, every cycle:
//   - each lane does win <= {D_IN[n], win[SEQ_W-1:1]};
//   - bit_idx counts 0..SEQ_W-1 and wraps; word_cnt increments on the wrap.
//   - nwin is the window including this cycle's bit. All compares use nwin.
//  Search (lane enabled, ~LOCKED, fill>=SEQ_W-1 so nwin is fully populated):
//   - on nwin==SEQUENCE: set LOCKED, set MATCH_COUNT=1, reset the lane phase counter to 0.
//  Locked lane:
//   - phase counter counts 0..SEQ_W-1; a compare event occurs each time it wraps to 0;
//   - nwin==SEQUENCE -> MATCH+1, else ERR+1;
//   - lock is never dropped during TRAIN.
//  Counters saturate at {CNT_W{1'b1}}. Disabled lanes never lock and never count.
//  DONE:
//   - set on entering FINISH;
//   - cleared by clear_p or by an accepted start_p;
//   - never set when AUTO_STOP=0.
//  clear_p in any state: state->IDLE; LOCKED, counts, DONE, windows and counters all cleared
//    the next cycle.
//  Leaving TRAIN by FINISH: LOCKED and all counts are held until the next start_p or clear_p.
//  ACTIVE = (state==TRAIN). Changing AUTO_STOP or LENGTH mid-TRAIN takes effect immediately.
//  Reset asserted mid-operation: everything returns to reset values asynchronously.
// TESTING
//  1. NUM_LANES=1, SEQUENCE=0xA5A5F00F, LENGTH=4, AUTO_STOP=1, aligned stream
//     -> LOCKED at shift 32; MATCH=4, ERR=0; ACTIVE 128 cycles, then DONE=1.
//  2. Lane stream delayed 5 bits, same LENGTH
//     -> lock at shift 37; compares at 69 and 101; MATCH=3, ERR=0 at DONE.
//  3. 4 lanes, LANE_EN=4'b1011; lane0 aligned; lane1 has one bit flipped in word 3;
//     lane3 offset 17; LENGTH=8
//     -> lane0 MATCH=8; lane1 MATCH=7, ERR=1; lane2 all 0; lane3 MATCH=7.
//  4. CLEAR rises at shift 50 of TRAIN -> IDLE next cycle; LOCKED, counts and DONE = 0.
//     START and CLEAR rise in the same cycle -> FSM stays in IDLE.
//  5. CNT_W=4, AUTO_STOP=0, aligned stream, 40 words -> MATCH saturates at 15; DONE stays 0;
//     ACTIVE stays 1 until CLEAR.
//  6. LENGTH=0, AUTO_STOP=1 -> ACTIVE for 1 cycle, FINISH, DONE=1, no lock.
//     RESETn pulsed low mid-TRAIN -> all outputs 0 immediately.

Source files
------------

// File: rtl/aha_tlx_multi_lane_trainer.sv
`default_nettype none
// ============================================================================
// Module      : aha_tlx_multi_lane_trainer
// Description : Multi-lane TLX training receiver. Each lane searches every bit
//               phase for SEQUENCE, locks word alignment, then counts matches
//               and errors once per word.
// Revision    : 1.0 - initial release
// ============================================================================
module aha_tlx_multi_lane_trainer #(
    parameter int NUM_LANES = 4,
    parameter int SEQ_W     = 32,
    parameter int CNT_W     = 32
) (
    input  logic                       CLK,
    input  logic                       RESETn,
    input  logic [NUM_LANES-1:0]       D_IN,
    input  logic [NUM_LANES-1:0]       LANE_EN,
    input  logic                       START,
    input  logic                       CLEAR,
    input  logic [SEQ_W-1:0]           SEQUENCE,
    input  logic [CNT_W-1:0]           LENGTH,
    input  logic                       AUTO_STOP,
    output logic                       DONE,
    output logic                       ACTIVE,
    output logic [NUM_LANES-1:0]       LOCKED,
    output logic [NUM_LANES*CNT_W-1:0] MATCH_COUNT,
    output logic [NUM_LANES*CNT_W-1:0] ERR_COUNT
);
    localparam int               IDX_W    = $clog2(SEQ_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 start_q, clear_q;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;
    logic                 filled_q, filled_d;
    logic                 done_q, done_d;
    logic [NUM_LANES-1:0] lane_en_q, lane_en_d;

    logic start_p, clear_p, train_start, train_run, fill_ok, cnt_done;

    assign start_p     = START & ~start_q;
    assign clear_p     = CLEAR & ~clear_q;
    assign train_start = (state_q == ST_IDLE) & start_p & ~clear_p;
    assign train_run   = (state_q == ST_TRAIN) & ~clear_p;
    // The window is fully populated once a whole word of bits has been shifted in.
    assign fill_ok     = filled_q | (bit_idx_q == LAST_IDX);
    assign cnt_done    = (LENGTH == '0) ||
                         ((bit_idx_q == LAST_IDX) && (word_cnt_q == LENGTH - CNT_W'(1)));

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        word_cnt_d = word_cnt_q;
        filled_d   = filled_q;
        done_d     = done_q;
        lane_en_d  = lane_en_q;
        if (clear_p || train_start) begin
            bit_idx_d  = '0;
            word_cnt_d = '0;
            filled_d   = 1'b0;
            done_d     = 1'b0;
        end
        if (train_start) begin
            lane_en_d = LANE_EN;
        end
        case (state_q)
            ST_IDLE: begin
                if (train_start) state_d = ST_TRAIN;
            end
            ST_TRAIN: begin
                if (clear_p) begin
                    state_d = ST_IDLE;
                end else begin
                    bit_idx_d = (bit_idx_q == LAST_IDX) ? '0 : bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_IDX) begin
                        word_cnt_d = word_cnt_q + 1'b1;
                        filled_d   = 1'b1;
                    end
                    if (AUTO_STOP && cnt_done) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            clear_q    <= 1'b0;
            bit_idx_q  <= '0;
            word_cnt_q <= '0;
            filled_q   <= 1'b0;
            done_q     <= 1'b0;
            lane_en_q  <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= START;
            clear_q    <= CLEAR;
            bit_idx_q  <= bit_idx_d;
            word_cnt_q <= word_cnt_d;
            filled_q   <= filled_d;
            done_q     <= done_d;
            lane_en_q  <= lane_en_d;
        end
    end

    assign DONE   = done_q;
    assign ACTIVE = (state_q == ST_TRAIN);

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        // Only the previous SEQ_W-1 bits are stored; the current bit completes the window.
        logic [SEQ_W-2:0] hist_q, hist_d;
        logic [IDX_W-1:0] phase_q, phase_d;
        logic [CNT_W-1:0] match_q, match_d;
        logic [CNT_W-1:0] err_q, err_d;
        logic             locked_q, locked_d;
        logic [SEQ_W-1:0] nwin;
        logic             hit;

        assign nwin = {D_IN[n], hist_q};
        assign hit  = (nwin == SEQUENCE);

        always_comb begin
            hist_d   = hist_q;
            phase_d  = phase_q;
            match_d  = match_q;
            err_d    = err_q;
            locked_d = locked_q;
            if (clear_p || train_start) begin
                hist_d   = '0;
                phase_d  = '0;
                match_d  = '0;
                err_d    = '0;
                locked_d = 1'b0;
            end else if (train_run) begin
                hist_d = nwin[SEQ_W-1:1];
                if (lane_en_q[n]) begin
                    if (!locked_q) begin
                        if (fill_ok && hit) begin
                            locked_d = 1'b1;
                            match_d  = CNT_W'(1);
                            phase_d  = '0;
                        end
                    end else begin
                        phase_d = (phase_q == LAST_IDX) ? '0 : phase_q + 1'b1;
                        if (phase_q == LAST_IDX) begin
                            if (hit) match_d = (match_q == CNT_MAX) ? match_q : match_q + 1'b1;
                            else     err_d   = (err_q == CNT_MAX) ? err_q : err_q + 1'b1;
                        end
                    end
                end
            end
        end

        always_ff @(posedge CLK or negedge RESETn) begin
            if (!RESETn) begin
                hist_q   <= '0;
                phase_q  <= '0;
                match_q  <= '0;
                err_q    <= '0;
                locked_q <= 1'b0;
            end else begin
                hist_q   <= hist_d;
                phase_q  <= phase_d;
                match_q  <= match_d;
                err_q    <= err_d;
                locked_q <= locked_d;
            end
        end

        assign LOCKED[n]                   = locked_q;
        assign MATCH_COUNT[n*CNT_W +: CNT_W] = match_q;
        assign ERR_COUNT[n*CNT_W +: CNT_W]   = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_aha_tlx_multi_lane_trainer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aha_tlx_multi_lane_trainer
// Description : Self-checking bench for aha_tlx_multi_lane_trainer with a
//               stream-level reference model and a small saturation instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aha_tlx_multi_lane_trainer;
    localparam int NL   = 4;
    localparam int SW   = 32;
    localparam int CW   = 32;
    localparam int MAXC = 320;
    localparam int NONE = 1 << 30;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NL-1:0]    d_in, lane_en, locked;
    logic             start, clear, auto_stop, done, active;
    logic [SW-1:0]    seq;
    logic [CW-1:0]    len;
    logic [NL*CW-1:0] match_cnt, err_cnt;

    logic       s_d_in, s_start, s_clear, s_done, s_active, s_locked;
    logic [3:0] s_seq, s_len, s_match, s_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [NL-1:0] stream [MAXC];
    int            exp_lock [NL];
    logic [CW-1:0] exp_m [NL];
    logic [CW-1:0] exp_e [NL];

    always #5 clk = ~clk;

    aha_tlx_multi_lane_trainer #(.NUM_LANES(NL), .SEQ_W(SW), .CNT_W(CW)) u_dut (
        .CLK(clk), .RESETn(rst_n), .D_IN(d_in), .LANE_EN(lane_en), .START(start),
        .CLEAR(clear), .SEQUENCE(seq), .LENGTH(len), .AUTO_STOP(auto_stop),
        .DONE(done), .ACTIVE(active), .LOCKED(locked),
        .MATCH_COUNT(match_cnt), .ERR_COUNT(err_cnt)
    );

    aha_tlx_multi_lane_trainer #(.NUM_LANES(1), .SEQ_W(4), .CNT_W(4)) u_dut_sat (
        .CLK(clk), .RESETn(rst_n), .D_IN(s_d_in), .LANE_EN(1'b1), .START(s_start),
        .CLEAR(s_clear), .SEQUENCE(s_seq), .LENGTH(s_len), .AUTO_STOP(1'b0),
        .DONE(s_done), .ACTIVE(s_active), .LOCKED(s_locked),
        .MATCH_COUNT(s_match), .ERR_COUNT(s_err)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] mc(input int n);
        return match_cnt[n*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] ec(input int n);
        return err_cnt[n*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] sat(input longint x);
        longint mx;
        mx = (longint'(1) << CW) - 1;
        return (x > mx) ? CW'(mx) : CW'(x);
    endfunction

    // Window seen at train cycle c: bit i is the bit received at cycle c-SW+1+i.
    function automatic logic [SW-1:0] window(input int n, input int c);
        logic [SW-1:0] w;
        for (int i = 0; i < SW; i++) w[i] = stream[c-SW+1+i][n];
        return w;
    endfunction

    task automatic set_lane(input int n, input logic [SW-1:0] sq, input int off, input bit noise);
        for (int c = 0; c < MAXC; c++)
            stream[c][n] = (noise || c < off) ? 1'($urandom) : sq[(c-off) % SW];
    endtask

    task automatic flip_bit(input int n, input int c);
        stream[c][n] = ~stream[c][n];
    endtask

    task automatic build_model(input logic [NL-1:0] en, input logic [SW-1:0] sq, input int t);
        longint m, e;
        for (int n = 0; n < NL; n++) begin
            m = 0;
            e = 0;
            exp_lock[n] = NONE;
            if (en[n]) begin
                for (int c = SW-1; c < t; c++) begin
                    if (window(n, c) == sq) begin
                        exp_lock[n] = c;
                        break;
                    end
                end
                if (exp_lock[n] != NONE) begin
                    m = 1;
                    for (int c = exp_lock[n] + SW; c < t; c += SW) begin
                        if (window(n, c) == sq) m++;
                        else e++;
                    end
                end
            end
            exp_m[n] = sat(m);
            exp_e[n] = sat(e);
        end
    endtask

    // Runs one training pass from IDLE; leaves status untouched for the caller.
    task automatic run_case(input string name, input logic [NL-1:0] en, input logic [SW-1:0] sq,
                            input int ln, input bit au, input int runc, input int spulse);
        int            t;
        logic [NL-1:0] expv;
        t = au ? ((ln == 0) ? 1 : ln * SW) : runc;
        build_model(en, sq, t);
        seq = sq; len = CW'(ln); auto_stop = au; lane_en = en;
        start = 1'b1;
        step();
        start = 1'b0;
        check_val({name, "_act_start"}, active, 1);
        for (int c = 0; c < t; c++) begin
            start = (c == spulse);
            d_in  = stream[c];
            step();
            for (int n = 0; n < NL; n++) expv[n] = (exp_lock[n] <= c);
            check_val($sformatf("%s_lock_c%0d", name, c), locked, expv);
            check_val($sformatf("%s_act_c%0d", name, c), active, ((c < t-1) || !au) ? 1 : 0);
        end
        start = 1'b0;
        d_in  = NL'($urandom);
        if (au) begin
            check_val({name, "_done_fin"}, done, 1);
            step();
            check_val({name, "_act_idle"}, active, 0);
            check_val({name, "_done_idle"}, done, 1);
        end else begin
            check_val({name, "_done_run"}, done, 0);
        end
        for (int n = 0; n < NL; n++) begin
            check_val($sformatf("%s_locked%0d", name, n), locked[n], (exp_lock[n] != NONE) ? 1 : 0);
            check_val($sformatf("%s_match%0d", name, n), mc(n), exp_m[n]);
            check_val($sformatf("%s_err%0d", name, n), ec(n), exp_e[n]);
        end
    endtask

    task automatic do_clear(input string name);
        clear = 1'b1;
        step();
        check_val({name, "_clr_act"}, active, 0);
        check_val({name, "_clr_done"}, done, 0);
        check_val({name, "_clr_lock"}, locked, 0);
        for (int n = 0; n < NL; n++) begin
            check_val($sformatf("%s_clr_m%0d", name, n), mc(n), 0);
            check_val($sformatf("%s_clr_e%0d", name, n), ec(n), 0);
        end
        clear = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [SW-1:0] rs;
        logic [NL-1:0] ren;
        int            mode, words, exp_sat;

        rst_n = 1'b0; d_in = '0; lane_en = '0; start = 1'b0; clear = 1'b0;
        seq = '0; len = '0; auto_stop = 1'b0;
        s_d_in = 1'b0; s_start = 1'b0; s_clear = 1'b0; s_seq = 4'b1001; s_len = '0;
        step(); step();
        check_val("rst_act", active, 0);
        check_val("rst_done", done, 0);
        check_val("rst_lock", locked, 0);
        check_val("rst_match", match_cnt[63:0], 0);
        check_val("rst_err", err_cnt[63:0], 0);
        rst_n = 1'b1;
        step();

        // Single enabled lane, aligned stream.
        for (int n = 0; n < NL; n++) set_lane(n, 32'hA5A5F00F, 0, 1);
        set_lane(0, 32'hA5A5F00F, 0, 0);
        run_case("t1", 4'b0001, 32'hA5A5F00F, 4, 1'b1, 0, -1);
        check_val("t1_spec_match", mc(0), 4);
        check_val("t1_spec_err", ec(0), 0);
        do_clear("t1");

        // Stream delayed by five bits.
        set_lane(0, 32'hA5A5F00F, 5, 0);
        run_case("t2", 4'b0001, 32'hA5A5F00F, 4, 1'b1, 0, -1);
        check_val("t2_spec_match", mc(0), 3);
        do_clear("t2");

        // Four lanes: aligned, single flipped bit in word 3, disabled, offset 17.
        set_lane(0, 32'hA5A5F00F, 0, 0);
        set_lane(1, 32'hA5A5F00F, 0, 0);
        flip_bit(1, 3*SW + $urandom_range(0, SW-1));
        set_lane(2, 32'hA5A5F00F, 0, 0);
        set_lane(3, 32'hA5A5F00F, 17, 0);
        run_case("t3", 4'b1011, 32'hA5A5F00F, 8, 1'b1, 0, -1);
        check_val("t3_spec_m0", mc(0), 8);
        check_val("t3_spec_m1", mc(1), 7);
        check_val("t3_spec_e1", ec(1), 1);
        check_val("t3_spec_m2", mc(2), 0);
        check_val("t3_spec_m3", mc(3), 7);
        do_clear("t3");

        // CLEAR rising mid-train, then START and CLEAR together.
        set_lane(0, 32'hA5A5F00F, 0, 0);
        seq = 32'hA5A5F00F; len = 4; auto_stop = 1'b1; lane_en = 4'b0001;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            d_in  = stream[c];
            clear = (c == 49);
            if (c == 49) check_val("t4_lock_before", locked, 4'b0001);
            step();
        end
        check_val("t4_act", active, 0);
        check_val("t4_lock", locked, 0);
        check_val("t4_match", mc(0), 0);
        check_val("t4_done", done, 0);
        clear = 1'b0;
        step();
        start = 1'b1; clear = 1'b1;
        step();
        check_val("t4_both_act", active, 0);
        start = 1'b0; clear = 1'b0;
        step();
        check_val("t4_both_act2", active, 0);

        // Zero length with auto stop.
        for (int n = 0; n < NL; n++) set_lane(n, 32'hA5A5F00F, 0, 0);
        run_case("t6", 4'b1111, 32'hA5A5F00F, 0, 1'b1, 0, -1);
        do_clear("t6");

        // Saturating counters on the narrow instance, free-running.
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        words = 40;
        for (int c = 0; c < words * 4; c++) begin
            s_d_in = s_seq[c % 4];
            step();
        end
        exp_sat = (words > 15) ? 15 : words;
        check_val("t5_match_sat", s_match, exp_sat);
        check_val("t5_err", s_err, 0);
        check_val("t5_locked", s_locked, 1);
        check_val("t5_done", s_done, 0);
        check_val("t5_active", s_active, 1);
        s_clear = 1'b1;
        step();
        check_val("t5_clr_act", s_active, 0);
        check_val("t5_clr_match", s_match, 0);
        s_clear = 1'b0;
        step();

        // Randomized passes against the stream model.
        for (int k = 0; k < 6; k++) begin
            rs  = SW'($urandom);
            ren = NL'($urandom_range(0, 15));
            for (int n = 0; n < NL; n++) begin
                mode = $urandom_range(0, 3);
                if (mode == 0)      set_lane(n, rs, 0, 0);
                else if (mode == 3) set_lane(n, rs, 0, 1);
                else                set_lane(n, rs, $urandom_range(1, 40), 0);
                if ($urandom_range(0, 1) == 1) flip_bit(n, $urandom_range(0, MAXC-1));
            end
            run_case($sformatf("rnd%0d", k), ren, rs, $urandom_range(1, 8),
                     ($urandom_range(0, 3) != 0), $urandom_range(40, 300), $urandom_range(2, 30));
            do_clear($sformatf("rnd%0d", k));
        end

        // Asynchronous reset during training.
        set_lane(0, 32'h1234ABCD, 0, 0);
        seq = 32'h1234ABCD; len = 8; auto_stop = 1'b1; lane_en = 4'b0001;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            d_in = stream[c];
            step();
        end
        check_val("rst_mid_lock_before", locked, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_mid_act", active, 0);
        check_val("rst_mid_lock", locked, 0);
        check_val("rst_mid_match", mc(0), 0);
        check_val("rst_mid_done", done, 0);
        step();
        rst_n = 1'b1;
        step();
        check_val("rst_mid_idle", active, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
